fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; the producer end of the decode stage's instruction interface.
- Owns the PC register and issues one-outstanding-request fetches to instruction memory over a req/ack interface with variable latency.
- Drives the IF/ID pipeline register: instruction word, PC and PC+4 into decode.
- Consumes decode's pc_src and the branch/jump target to redirect, and honours decode stalls.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and address.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INS, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_d  in  1  decode cannot accept; IF/ID holds.
- pc_src  in  1  redirect/flush request from decode.
- pc_target_e  in  DATA_WIDTH  redirect address, valid with pc_src.
- imem_ack  in  1  one-cycle response strobe, exactly one per request.
- imem_rdata  in  DATA_WIDTH  instruction word, valid with imem_ack.
- imem_req  out  1  one-cycle request strobe.
- imem_addr  out  DATA_WIDTH  fetch address (= pc_f), valid with imem_req.
- ins  out  DATA_WIDTH  IF/ID instruction to decode.
- pc_d  out  DATA_WIDTH  PC of ins.
- pc_plus_4d  out  DATA_WIDTH  pc_d + 4.
- valid_d  out  1  ins is a real fetched instruction (0 = bubble).

Behaviour:
- Reset (async): state=IDLE; pc_f=RESET_PC; ins=NOP_INS; pc_d=0; pc_plus_4d=0; valid_d=0; discard=0; hold buffer=0. imem_req=0 throughout reset.
- imem_req = (state==ISSUE) && !pc_src. imem_addr = pc_f at all times.
- IDLE: unconditionally -> ISSUE next cycle.
- ISSUE:
  - pc_src=1: pc_f<=pc_target_e; no request; stay in ISSUE.
  - Otherwise: request issued; -> WAIT.
- WAIT, no ack:
  - pc_src=1: pc_f<=pc_target_e; discard<=1.
- WAIT, imem_ack=1:
  - discard=1: drop data; discard<=0; -> ISSUE.
  - pc_src=1 in the same cycle: drop data; pc_f<=pc_target_e; -> ISSUE.
  - stall_d=0: load IF/ID (ins<=imem_rdata, pc_d<=pc_f, pc_plus_4d<=pc_f+4, valid_d<=1); pc_f<=pc_f+4; -> ISSUE.
  - stall_d=1: capture rdata into hold buffer; -> HOLD.
- HOLD:
  - pc_src=1: drop buffer; pc_f<=pc_target_e; -> ISSUE.
  - stall_d=0: load IF/ID from buffer as above; pc_f<=pc_f+4; -> ISSUE.
  - Otherwise: wait.
- IF/ID update, priority pc_src > stall_d > load > bubble:
  - pc_src: ins<=NOP_INS, valid_d<=0, pc_d/pc_plus_4d<=0 (flush).
  - stall_d: all IF/ID outputs hold.
  - No instruction ready and not stalled: insert bubble (NOP_INS, valid_d=0, pc_d/pc_plus_4d hold).
- Arithmetic: pc_f+4 is modulo 2^DATA_WIDTH and wraps silently. pc_target_e bits[1:0] are used as given; no alignment check.
- Throughput: one instruction per 2 cycles at ack latency 1; one per (latency+1) in general.
- Reset mid-operation: all state clears immediately. Instruction memory shares rst and cancels any outstanding request. imem_ack while in IDLE or ISSUE is a protocol error; it is ignored and causes no state change.
- Only one request is ever outstanding; no request is issued while in WAIT or HOLD.

Test Plan:
- Release rst, memory with 1-cycle ack, rdata 32'h0050_0093 at addr 0 -> imem_req high with addr 0x0 in the 2nd cycle after release; next edge ins=0x00500093, pc_d=0, pc_plus_4d=4, valid_d=1; next request addr 0x4.
- stall_d=1 from before ack of addr 0x4 (rdata 0x00A00113) for 3 cycles -> IF/ID holds the previous instruction, no new imem_req; on stall release ins=0x00A00113, pc_d=4, then request addr 0x8.
- Request addr 0x8, ack latency 3; pulse pc_src with pc_target_e=0x40 one cycle after the request -> ins=NOP, valid_d=0; late ack (0xDEADBEEF) dropped; next request addr 0x40.
- pc_src=1 in the same cycle as imem_ack -> data dropped, IF/ID flushed to NOP, next request addr 0x40, exactly one request issued.
- Assert rst while in WAIT -> outputs immediately ins=0x13, valid_d=0, imem_req=0; after release, first request addr RESET_PC.
- pc_target_e=0xFFFF_FFFC then sequential fetch -> pc_plus_4d=0x0000_0000 and next request addr 0x0 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues single-outstanding imem
// requests, and drives the IF/ID register into decode.
module fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0] NOP_INS    = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_d,
   input  logic                  pc_src,
   input  logic [DATA_WIDTH-1:0] pc_target_e,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] ins,
   output logic [DATA_WIDTH-1:0] pc_d,
   output logic [DATA_WIDTH-1:0] pc_plus_4d,
   output logic                  valid_d
);

   // state   | meaning
   // S_IDLE  | one settling cycle after reset
   // S_ISSUE | request strobe for pc_f this cycle (suppressed by pc_src)
   // S_WAIT  | request outstanding, waiting for imem_ack
   // S_HOLD  | fetched word parked in hold_buf while decode stalls
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

   state_t                state, state_next;
   logic [DATA_WIDTH-1:0] pc_f, pc_next, pc_inc;
   logic [DATA_WIDTH-1:0] hold_buf, hold_next, load_data;
   logic                  discard, discard_next, load;

   assign pc_inc    = pc_f + DATA_WIDTH'(4);
   assign imem_req  = (state == S_ISSUE) && !pc_src;
   assign imem_addr = pc_f;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         pc_f     <= RESET_PC;
         discard  <= 1'b0;
         hold_buf <= '0;
      end else begin
         state    <= state_next;
         pc_f     <= pc_next;
         discard  <= discard_next;
         hold_buf <= hold_next;
      end
   end

   always_comb begin
      state_next   = state;
      pc_next      = pc_f;
      discard_next = discard;
      hold_next    = hold_buf;
      load         = 1'b0;
      load_data    = hold_buf;
      case (state)
         S_IDLE: state_next = S_ISSUE;
         S_ISSUE: begin
            if (pc_src) pc_next = pc_target_e;
            else        state_next = S_WAIT;
         end
         S_WAIT: begin
            if (imem_ack) begin
               state_next = S_ISSUE;
               if (discard) begin
                  // stale response of a redirected fetch; a fresh redirect still lands
                  discard_next = 1'b0;
                  if (pc_src) pc_next = pc_target_e;
               end else if (pc_src) begin
                  pc_next = pc_target_e;
               end else if (!stall_d) begin
                  load      = 1'b1;
                  load_data = imem_rdata;
                  pc_next   = pc_inc;
               end else begin
                  hold_next  = imem_rdata;
                  state_next = S_HOLD;
               end
            end else if (pc_src) begin
               pc_next      = pc_target_e;
               discard_next = 1'b1;
            end
         end
         S_HOLD: begin
            if (pc_src) begin
               pc_next    = pc_target_e;
               state_next = S_ISSUE;
            end else if (!stall_d) begin
               load       = 1'b1;
               pc_next    = pc_inc;
               state_next = S_ISSUE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // IF/ID register: flush > stall > load > bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ins        <= NOP_INS;
         pc_d       <= '0;
         pc_plus_4d <= '0;
         valid_d    <= 1'b0;
      end else if (pc_src) begin
         ins        <= NOP_INS;
         pc_d       <= '0;
         pc_plus_4d <= '0;
         valid_d    <= 1'b0;
      end else if (stall_d) begin
         ins        <= ins;
      end else if (load) begin
         ins        <= load_data;
         pc_d       <= pc_f;
         pc_plus_4d <= pc_inc;
         valid_d    <= 1'b1;
      end else begin
         ins        <= NOP_INS;
         valid_d    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small latency-programmable imem responder
// plus hand-computed IF/ID and request expectations.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_d = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] pc_target_e = '0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] ins;
   logic [31:0] pc_d;
   logic [31:0] pc_plus_4d;
   logic        valid_d;

   int          n_vec = 0;
   int          n_err = 0;
   int          lat = 1;
   int          cnt = 0;
   int          req_count = 0;
   int          req_base = 0;
   logic        pend = 1'b0;
   logic [31:0] paddr = '0;
   logic        seen_req = 1'b0;
   logic [31:0] seen_addr = '0;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall_d     (stall_d),
      .pc_src      (pc_src),
      .pc_target_e (pc_target_e),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .ins         (ins),
      .pc_d        (pc_d),
      .pc_plus_4d  (pc_plus_4d),
      .valid_d     (valid_d)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h00A0_0113;
         32'h0000_0008: return 32'hDEAD_BEEF;
         32'h0000_0040: return 32'h0000_0513;
         32'hFFFF_FFFC: return 32'h1234_5678;
         default:       return 32'hBAD0_0000;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one clock: sample request before the edge, then drive the memory response for the next cycle
   task automatic tick();
      @(negedge clk);
      seen_req  = imem_req;
      seen_addr = imem_addr;
      if (imem_req === 1'b1) req_count++;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (rst) begin
         pend = 1'b0;
      end else if (seen_req) begin
         if (lat == 1) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_data(seen_addr);
         end else begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = seen_addr;
         end
      end else if (pend) begin
         if (cnt == 1) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_data(paddr);
            pend       = 1'b0;
         end else begin
            cnt--;
         end
      end
   endtask

   initial begin
      // reset state
      tick();
      tick();
      check_eq("rst_ins", ins, NOP);
      check_eq("rst_valid", {31'd0, valid_d}, 32'd0);
      check_eq("rst_pc_d", pc_d, 32'd0);
      check_eq("rst_req", {31'd0, imem_req}, 32'd0);

      // first fetch, latency 1
      rst = 1'b0;
      tick();
      check_eq("idle_noreq", {31'd0, seen_req}, 32'd0);
      tick();
      check_eq("req0", {31'd0, seen_req}, 32'd1);
      check_eq("req0_addr", seen_addr, 32'h0);
      tick();
      check_eq("ld0_ins", ins, 32'h0050_0093);
      check_eq("ld0_pc", pc_d, 32'h0);
      check_eq("ld0_pc4", pc_plus_4d, 32'h4);
      check_eq("ld0_valid", {31'd0, valid_d}, 32'd1);

      // stall across the ack of addr 4
      stall_d = 1'b1;
      tick();
      check_eq("req4_addr", seen_addr, 32'h4);
      check_eq("req4", {31'd0, seen_req}, 32'd1);
      req_base = req_count;
      tick();
      check_eq("stall_ins_a", ins, 32'h0050_0093);
      tick();
      check_eq("stall_ins_b", ins, 32'h0050_0093);
      check_eq("stall_valid", {31'd0, valid_d}, 32'd1);
      stall_d = 1'b0;
      tick();
      check_eq("stall_noreq", req_count - req_base, 32'd0);
      check_eq("ld4_ins", ins, 32'h00A0_0113);
      check_eq("ld4_pc", pc_d, 32'h4);
      check_eq("ld4_pc4", pc_plus_4d, 32'h8);

      // redirect while a latency-3 fetch of addr 8 is outstanding
      lat = 3;
      tick();
      check_eq("req8_addr", seen_addr, 32'h8);
      check_eq("bubble_ins", ins, NOP);
      check_eq("bubble_pc_hold", pc_d, 32'h4);
      pc_src      = 1'b1;
      pc_target_e = 32'h40;
      tick();
      check_eq("redir_ins", ins, NOP);
      check_eq("redir_pc_d", pc_d, 32'h0);
      pc_src = 1'b0;
      tick();
      tick();
      check_eq("late_ack_seen", {31'd0, imem_ack}, 32'd0);
      check_eq("late_drop_ins", ins, NOP);
      check_eq("late_drop_valid", {31'd0, valid_d}, 32'd0);
      lat = 1;
      tick();
      check_eq("req40_addr", seen_addr, 32'h40);
      check_eq("req40", {31'd0, seen_req}, 32'd1);

      // redirect in the same cycle as the ack
      pc_src      = 1'b1;
      pc_target_e = 32'h40;
      req_base    = req_count;
      tick();
      check_eq("ackflush_ins", ins, NOP);
      check_eq("ackflush_valid", {31'd0, valid_d}, 32'd0);
      pc_src = 1'b0;
      tick();
      check_eq("refetch_addr", seen_addr, 32'h40);
      tick();
      check_eq("one_req", req_count - req_base, 32'd1);
      check_eq("ld40_ins", ins, 32'h0000_0513);
      check_eq("ld40_pc", pc_d, 32'h40);
      check_eq("ld40_pc4", pc_plus_4d, 32'h44);

      // reset while WAIT
      tick();
      check_eq("req44_addr", seen_addr, 32'h44);
      rst = 1'b1;
      #1;
      imem_ack = 1'b0;
      pend     = 1'b0;
      check_eq("midrst_ins", ins, NOP);
      check_eq("midrst_valid", {31'd0, valid_d}, 32'd0);
      check_eq("midrst_req", {31'd0, imem_req}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check_eq("post_rst_req", {31'd0, seen_req}, 32'd1);
      check_eq("post_rst_addr", seen_addr, 32'h0);
      tick();
      check_eq("post_rst_ins", ins, 32'h0050_0093);

      // PC wrap
      pc_src      = 1'b1;
      pc_target_e = 32'hFFFF_FFFC;
      tick();
      check_eq("redir_issue_noreq", {31'd0, seen_req}, 32'd0);
      pc_src = 1'b0;
      tick();
      check_eq("reqtop_addr", seen_addr, 32'hFFFF_FFFC);
      tick();
      check_eq("top_ins", ins, 32'h1234_5678);
      check_eq("top_pc", pc_d, 32'hFFFF_FFFC);
      check_eq("wrap_pc4", pc_plus_4d, 32'h0);
      tick();
      check_eq("wrap_addr", seen_addr, 32'h0);
      check_eq("wrap_req", {31'd0, seen_req}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
